// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the memory read arbiter.
// Holds FSM states (one-hot), owner codes and width defaults.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int BEAT_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_RSP  = 3'b100
  } arb_state_e;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

endpackage

// File: rtl/mem_rd_arbiter_arb2_grant.sv
// arb2_grant: two-input grant logic (I-cache / D-cache).
// Ports: i_req_ic, i_req_dc, i_last_owner -> o_gnt_ic, o_gnt_dc.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin on contention,
// otherwise the D-cache always wins a tie.
module arb2_grant
  import mem_arb_pkg::*;
(
  input  logic i_req_ic,
  input  logic i_req_dc,
  input  logic i_last_owner,
  output logic o_gnt_ic,
  output logic o_gnt_dc
);

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie, hand the grant to whoever did not own the last burst.
  assign o_gnt_dc = i_req_dc &
                    (~i_req_ic | (i_last_owner == OWN_IC));
  assign o_gnt_ic = i_req_ic &
                    (~i_req_dc | (i_last_owner == OWN_DC));
`else
  logic w_unused_last;

  assign w_unused_last = i_last_owner;
  assign o_gnt_dc      = i_req_dc;
  assign o_gnt_ic      = i_req_ic & ~i_req_dc;
`endif

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: routes I-cache and D-cache burst reads onto one
// memory read channel, one transaction outstanding at a time.
// Ports: ic_rd_req/rsp_*, dc_rd_req/rsp_* (masters), mem_rd_req/rsp_*
// (memory), arb_busy, beat_cnt. Synchronous active-high rst.
// Build option: ARB_ROUND_ROBIN_EN (round-robin on simultaneous
// requests; default is fixed D-cache priority).
module mem_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_W_DEF,
  parameter int DATA_WIDTH     = DATA_W_DEF,
  parameter int BEAT_CNT_WIDTH = BEAT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      ic_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0]     ic_rd_req_addr,
  output logic                      ic_rd_req_ready,
  output logic                      ic_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]     ic_rd_rsp_data,
  output logic                      ic_rd_rsp_last,
  input  logic                      ic_rd_rsp_ready,

  input  logic                      dc_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0]     dc_rd_req_addr,
  output logic                      dc_rd_req_ready,
  output logic                      dc_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]     dc_rd_rsp_data,
  output logic                      dc_rd_rsp_last,
  input  logic                      dc_rd_rsp_ready,

  output logic                      mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0]     mem_rd_req_addr,
  input  logic                      mem_rd_req_ready,
  input  logic                      mem_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rd_rsp_data,
  input  logic                      mem_rd_rsp_last,
  output logic                      mem_rd_rsp_ready,

  output logic                      arb_busy,
  output logic [BEAT_CNT_WIDTH-1:0] beat_cnt
);

  arb_state_e                r_state;
  logic                      r_owner;
  logic                      r_last_owner;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [BEAT_CNT_WIDTH-1:0] r_beat_cnt;

  logic w_idle;
  logic w_req;
  logic w_rsp;
  logic w_gnt_ic;
  logic w_gnt_dc;
  logic w_own_ic;
  logic w_own_dc;
  logic w_beat_hs;

  // Handshake outputs are masked by rst so they are low during the
  // reset cycle even before the state register has been cleared.
  assign w_idle = (r_state == ST_IDLE) & ~rst;
  assign w_req  = (r_state == ST_REQ) & ~rst;
  assign w_rsp  = (r_state == ST_RSP) & ~rst;

  arb2_grant u_grant (
    .i_req_ic     (ic_rd_req_valid),
    .i_req_dc     (dc_rd_req_valid),
    .i_last_owner (r_last_owner),
    .o_gnt_ic     (w_gnt_ic),
    .o_gnt_dc     (w_gnt_dc)
  );

  assign ic_rd_req_ready = w_idle & w_gnt_ic;
  assign dc_rd_req_ready = w_idle & w_gnt_dc;

  assign mem_rd_req_valid = w_req;
  assign mem_rd_req_addr  = r_addr;

  assign w_own_ic = w_rsp & (r_owner == OWN_IC);
  assign w_own_dc = w_rsp & (r_owner == OWN_DC);

  assign ic_rd_rsp_valid = w_own_ic & mem_rd_rsp_valid;
  assign ic_rd_rsp_data  = w_own_ic ? mem_rd_rsp_data : '0;
  assign ic_rd_rsp_last  = w_own_ic & mem_rd_rsp_last;

  assign dc_rd_rsp_valid = w_own_dc & mem_rd_rsp_valid;
  assign dc_rd_rsp_data  = w_own_dc ? mem_rd_rsp_data : '0;
  assign dc_rd_rsp_last  = w_own_dc & mem_rd_rsp_last;

  assign mem_rd_rsp_ready = (w_own_ic & ic_rd_rsp_ready) |
                            (w_own_dc & dc_rd_rsp_ready);

  assign w_beat_hs = mem_rd_rsp_valid & mem_rd_rsp_ready;

  assign arb_busy = (r_state != ST_IDLE);
  assign beat_cnt = r_beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_DC;
      r_last_owner <= OWN_DC;
      r_addr       <= '0;
      r_beat_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_gnt_dc | w_gnt_ic) begin
            r_addr     <= w_gnt_dc ? dc_rd_req_addr
                                   : ic_rd_req_addr;
            r_owner    <= w_gnt_dc ? OWN_DC : OWN_IC;
            r_beat_cnt <= '0;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_rd_req_ready) begin
            r_state <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (w_beat_hs) begin
            if (r_beat_cnt != '1) begin
              r_beat_cnt <= r_beat_cnt + BEAT_CNT_WIDTH'(1);
            end
            if (mem_rd_rsp_last) begin
              r_last_owner <= r_owner;
              r_state      <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference.
module tb_mem_rd_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_rd_req_valid, dc_rd_req_valid;
  logic [31:0] ic_rd_req_addr, dc_rd_req_addr;
  logic        ic_rd_req_ready, dc_rd_req_ready;
  logic        ic_rd_rsp_valid, dc_rd_rsp_valid;
  logic [31:0] ic_rd_rsp_data, dc_rd_rsp_data;
  logic        ic_rd_rsp_last, dc_rd_rsp_last;
  logic        ic_rd_rsp_ready, dc_rd_rsp_ready;
  logic        mem_rd_req_valid, mem_rd_req_ready;
  logic [31:0] mem_rd_req_addr;
  logic        mem_rd_rsp_valid, mem_rd_rsp_last, mem_rd_rsp_ready;
  logic [31:0] mem_rd_rsp_data;
  logic        arb_busy;
  logic [3:0]  beat_cnt;

  always #5 clk = ~clk;

  mem_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_rd_req_valid(ic_rd_req_valid), .ic_rd_req_addr(ic_rd_req_addr),
    .ic_rd_req_ready(ic_rd_req_ready), .ic_rd_rsp_valid(ic_rd_rsp_valid),
    .ic_rd_rsp_data(ic_rd_rsp_data), .ic_rd_rsp_last(ic_rd_rsp_last),
    .ic_rd_rsp_ready(ic_rd_rsp_ready),
    .dc_rd_req_valid(dc_rd_req_valid), .dc_rd_req_addr(dc_rd_req_addr),
    .dc_rd_req_ready(dc_rd_req_ready), .dc_rd_rsp_valid(dc_rd_rsp_valid),
    .dc_rd_rsp_data(dc_rd_rsp_data), .dc_rd_rsp_last(dc_rd_rsp_last),
    .dc_rd_rsp_ready(dc_rd_rsp_ready),
    .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_addr(mem_rd_req_addr),
    .mem_rd_req_ready(mem_rd_req_ready), .mem_rd_rsp_valid(mem_rd_rsp_valid),
    .mem_rd_rsp_data(mem_rd_rsp_data), .mem_rd_rsp_last(mem_rd_rsp_last),
    .mem_rd_rsp_ready(mem_rd_rsp_ready),
    .arb_busy(arb_busy), .beat_cnt(beat_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference: phase 0 idle, 1 request out, 2 collecting beats
  int          m_st;
  logic        m_own, m_last;
  logic [31:0] m_addr;
  int          m_cnt;

  // master and memory stimulus state
  bit          ic_v, dc_v;
  logic [31:0] ic_a, dc_a;
  int k_ir = 100, k_dr = 100, k_mq = 100, k_mr = 100;
  int len_fix = 8;
  bit mem_out, pend;
  int beats_left, idx, burst_id;
  logic [31:0] p_data;
  logic        p_last;

  logic [31:0] ic_got[$], dc_got[$], addr_q[$];
  bit          ic_lq[$], dc_lq[$];
  logic [31:0] x0, x1;

  function automatic bit pct(int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_q();
    ic_got.delete(); dc_got.delete(); addr_q.delete();
    ic_lq.delete(); dc_lq.delete();
  endtask

  task automatic step();
    logic g_ic, g_dc, idl, rs, own_ic, own_dc, e_mrr;
    ic_rd_req_valid = ic_v; ic_rd_req_addr = ic_a;
    dc_rd_req_valid = dc_v; dc_rd_req_addr = dc_a;
    ic_rd_rsp_ready = pct(k_ir);
    dc_rd_rsp_ready = pct(k_dr);
    mem_rd_req_ready = pct(k_mq);
    if (mem_out && !pend && pct(k_mr)) begin
      pend   = 1;
      p_data = 32'(burst_id << 16) | 32'((idx + 1) * 17);
      p_last = (beats_left == 1);
    end
    mem_rd_rsp_valid = pend;
    mem_rd_rsp_data  = pend ? p_data : $urandom;
    mem_rd_rsp_last  = pend ? p_last : 1'($urandom);
    #1;
    idl = (m_st == 0) && !rst;
    g_dc = dc_v;
    g_ic = ic_v && !dc_v;
`ifdef ARB_ROUND_ROBIN_EN
    if (ic_v && dc_v) begin
      g_dc = (m_last == OWN_IC);
      g_ic = (m_last == OWN_DC);
    end
`endif
    rs = (m_st == 2) && !rst;
    own_ic = rs && (m_own == OWN_IC);
    own_dc = rs && (m_own == OWN_DC);
    e_mrr = (own_ic && ic_rd_rsp_ready) || (own_dc && dc_rd_rsp_ready);
    chk("ic_req_ready", 32'(ic_rd_req_ready), 32'(idl && g_ic));
    chk("dc_req_ready", 32'(dc_rd_req_ready), 32'(idl && g_dc));
    chk("ic_rsp_valid", 32'(ic_rd_rsp_valid), 32'(own_ic && mem_rd_rsp_valid));
    chk("dc_rsp_valid", 32'(dc_rd_rsp_valid), 32'(own_dc && mem_rd_rsp_valid));
    chk("mem_rsp_ready", 32'(mem_rd_rsp_ready), 32'(e_mrr));
    chk("mem_req_valid", 32'(mem_rd_req_valid), 32'((m_st == 1) && !rst));
    if (!rst) begin
      chk("ic_rsp_data", ic_rd_rsp_data, own_ic ? mem_rd_rsp_data : 32'h0);
      chk("dc_rsp_data", dc_rd_rsp_data, own_dc ? mem_rd_rsp_data : 32'h0);
      chk("ic_rsp_last", 32'(ic_rd_rsp_last), 32'(own_ic && mem_rd_rsp_last));
      chk("dc_rsp_last", 32'(dc_rd_rsp_last), 32'(own_dc && mem_rd_rsp_last));
      chk("mem_req_addr", mem_rd_req_addr, m_addr);
      chk("arb_busy", 32'(arb_busy), 32'(m_st != 0));
      chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    end
    if (rst) begin
      m_st = 0; m_own = OWN_DC; m_last = OWN_DC;
      m_addr = 0; m_cnt = 0;
      ic_v = 0; dc_v = 0; mem_out = 0; pend = 0;
    end else if (m_st == 0) begin
      if (g_dc) begin
        m_addr = dc_a; m_own = OWN_DC; m_cnt = 0; m_st = 1; dc_v = 0;
      end else if (g_ic) begin
        m_addr = ic_a; m_own = OWN_IC; m_cnt = 0; m_st = 1; ic_v = 0;
      end
    end else if (m_st == 1) begin
      if (mem_rd_req_ready) begin
        addr_q.push_back(mem_rd_req_addr);
        m_st = 2; mem_out = 1; idx = 0;
        beats_left = (len_fix != 0) ? len_fix
                                    : int'($urandom_range(12, 1));
      end
    end else begin
      if (pend && e_mrr) begin
        if (m_cnt < 15) m_cnt++;
        if (own_ic) begin
          ic_got.push_back(p_data); ic_lq.push_back(p_last);
        end else begin
          dc_got.push_back(p_data); dc_lq.push_back(p_last);
        end
        pend = 0; idx++; beats_left--;
        if (p_last) begin
          m_last = m_own; m_st = 0; mem_out = 0; burst_id++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_done(string nm);
    int i = 0;
    do begin
      step();
      i++;
    end while (!(m_st == 0 && !ic_v && !dc_v) && i < 400);
    n_vec++;
    if (i >= 400) begin
      n_err++;
      $display("FAIL %s: timeout after %0d cycles", nm, i);
    end
  endtask

  task automatic run_to_beat(int b);
    for (int i = 0; i < 100 && !(m_st == 2 && m_cnt == b); i++) step();
  endtask

  function automatic logic [31:0] qget(int k);
    return (addr_q.size() > k) ? addr_q[k] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    rst = 1;
    {ic_rd_req_valid, dc_rd_req_valid} = '0;
    {ic_rd_req_addr, dc_rd_req_addr} = '0;
    {ic_rd_rsp_ready, dc_rd_rsp_ready, mem_rd_req_ready} = '0;
    {mem_rd_rsp_valid, mem_rd_rsp_last} = '0;
    mem_rd_rsp_data = '0;
    ic_a = 0; dc_a = 0; burst_id = 0;
    @(negedge clk);
    step(); step();
    rst = 0;
    #1;
    chk("rst_busy", 32'(arb_busy), 32'h0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'h0);
    chk("rst_addr", mem_rd_req_addr, 32'h0);
    chk("rst_req_valid", 32'(mem_rd_req_valid), 32'h0);

    // simultaneous requests
    clr_q();
    ic_v = 1; ic_a = 32'h100; dc_v = 1; dc_a = 32'h200;
    run_done("both_req");
`ifdef ARB_ROUND_ROBIN_EN
    x0 = 32'h100; x1 = 32'h200;
`else
    x0 = 32'h200; x1 = 32'h100;
`endif
    chk("tie_first", qget(0), x0);
    chk("tie_second", qget(1), x1);
    chk("tie_ic_beats", ic_got.size(), 32'd8);
    chk("tie_dc_beats", dc_got.size(), 32'd8);

    // I-cache only, memory slow to accept
    clr_q(); burst_id = 0;
    ic_v = 1; ic_a = 32'h0000_1A40; k_mq = 0;
    step(); step(); step();
    k_mq = 100;
    run_done("ic_only");
    chk("ic_addr", qget(0), 32'h0000_1A40);
    chk("ic_nbeats", ic_got.size(), 32'd8);
    for (int i = 0; i < 8 && i < ic_got.size(); i++)
      chk("ic_beat", ic_got[i], 32'((i + 1) * 17));
    if (ic_lq.size() == 8) begin
      chk("ic_last_on_88", 32'(ic_lq[7]), 32'h1);
      chk("ic_no_early_last", 32'(ic_lq[6]), 32'h0);
    end
    chk("ic_dc_quiet", dc_got.size(), 32'd0);
    chk("ic_beat_cnt", 32'(beat_cnt), 32'd8);

    // owner backpressure at beat 4
    clr_q();
    dc_v = 1; dc_a = 32'h300;
    run_to_beat(4);
    k_dr = 0;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("bp_mem_ready", 32'(mem_rd_rsp_ready), 32'h0);
      chk("bp_beat_cnt", 32'(beat_cnt), 32'd4);
    end
    k_dr = 100;
    run_done("backpressure");
    chk("bp_nbeats", dc_got.size(), 32'd8);
    for (int i = 0; i < 8 && i < dc_got.size(); i++)
      chk("bp_beat", 32'(dc_got[i][15:0]), 32'((i + 1) * 17));

    // memory stalls the request
    clr_q();
    dc_v = 1; dc_a = 32'h400; k_mq = 0;
    step();
    ic_v = 1; ic_a = 32'h480;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("stall_valid", 32'(mem_rd_req_valid), 32'h1);
      chk("stall_addr", mem_rd_req_addr, 32'h400);
      chk("stall_ic_rdy", 32'(ic_rd_req_ready), 32'h0);
    end
    k_mq = 100;
    run_done("stall");
    chk("stall_order0", qget(0), 32'h400);
    chk("stall_order1", qget(1), 32'h480);

    // reset during beat 3
    clr_q();
    ic_v = 1; ic_a = 32'h500;
    run_to_beat(3);
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("mid_rst_busy", 32'(arb_busy), 32'h0);
    chk("mid_rst_cnt", 32'(beat_cnt), 32'h0);
    chk("mid_rst_mrr", 32'(mem_rd_rsp_ready), 32'h0);
    chk("mid_rst_mqv", 32'(mem_rd_req_valid), 32'h0);
    chk("mid_rst_irv", 32'(ic_rd_rsp_valid), 32'h0);
    clr_q();
    dc_v = 1; dc_a = 32'h600;
    run_done("after_rst");
    chk("after_rst_addr", qget(0), 32'h600);
    chk("after_rst_beats", dc_got.size(), 32'd8);

    // long burst saturates the counter
    len_fix = 18;
    dc_v = 1; dc_a = 32'h700;
    run_done("saturate");
    chk("sat_beat_cnt", 32'(beat_cnt), 32'd15);
    len_fix = 0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        k_ir = int'($urandom_range(100, 30));
        k_dr = int'($urandom_range(100, 30));
        k_mq = int'($urandom_range(100, 20));
        k_mr = int'($urandom_range(100, 30));
      end
      if (!ic_v && pct(25)) begin
        ic_v = 1; ic_a = $urandom & 32'hFFFF_FFE0;
      end
      if (!dc_v && pct(25)) begin
        dc_v = 1; dc_a = $urandom & 32'hFFFF_FFE0;
      end
      rst = ($urandom_range(999) == 0);
      step();
      rst = 0;
    end
    k_ir = 100; k_dr = 100; k_mq = 100; k_mr = 100;
    run_done("drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Two-master read arbiter between the instruction cache and data cache miss paths and the single memory read channel.
- Sits directly downstream of the I-cache memory interface (to_mem_rd_req_*, from_mem_rd_rsp_*).
- Accepts one burst read request at a time, forwards it to memory, and routes every response beat back to the requester until the beat flagged last.
- Exactly one transaction is outstanding; the grant is held for the whole burst.

Parameters:
ADDR_WIDTH, 32, request address width (addresses 32-byte aligned by masters)
DATA_WIDTH, 32, width of one response beat
BEAT_CNT_WIDTH, 4, width of the per-burst beat counter (8-beat lines; saturates)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ic_rd_req_valid  in  1  I-cache read request valid
ic_rd_req_addr  in  ADDR_WIDTH  I-cache request address
ic_rd_req_ready  out  1  arbiter accepts I-cache request
ic_rd_rsp_valid  out  1  beat valid to I-cache
ic_rd_rsp_data  out  DATA_WIDTH  beat data to I-cache
ic_rd_rsp_last  out  1  last beat to I-cache
ic_rd_rsp_ready  in  1  I-cache accepts beat
dc_rd_req_valid  in  1  D-cache read request valid
dc_rd_req_addr  in  ADDR_WIDTH  D-cache request address
dc_rd_req_ready  out  1  arbiter accepts D-cache request
dc_rd_rsp_valid  out  1  beat valid to D-cache
dc_rd_rsp_data  out  DATA_WIDTH  beat data to D-cache
dc_rd_rsp_last  out  1  last beat to D-cache
dc_rd_rsp_ready  in  1  D-cache accepts beat
mem_rd_req_valid  out  1  request valid to memory
mem_rd_req_addr  out  ADDR_WIDTH  registered request address
mem_rd_req_ready  in  1  memory accepts request
mem_rd_rsp_valid  in  1  memory beat valid
mem_rd_rsp_data  in  DATA_WIDTH  memory beat data
mem_rd_rsp_last  in  1  memory last beat
mem_rd_rsp_ready  out  1  arbiter accepts beat
arb_busy  out  1  transaction in flight (state != IDLE)
beat_cnt  out  BEAT_CNT_WIDTH  beats received in current burst

Behaviour:
- Reset: state = IDLE, owner = DC, last_owner = DC, addr register = 0, beat_cnt = 0.
  - All valid/ready outputs are 0 while rst is high.
  - Reset mid-burst returns to IDLE immediately; remaining memory beats are not accepted.
- States: IDLE, REQ, RSP, one-hot.
- IDLE:
  - grant_dc = dc_rd_req_valid; grant_ic = ic_rd_req_valid & ~dc_rd_req_valid (fixed priority, D-cache first).
  - x_rd_req_ready = (state==IDLE) & grant_x, combinational.
  - On valid&ready: latch addr and owner, beat_cnt <= 0, go to REQ next cycle.
  - With no request, stay in IDLE.
- REQ:
  - mem_rd_req_valid = 1; mem_rd_req_addr = latched addr, stable until handshake.
  - On mem_rd_req_ready go to RSP; otherwise hold.
  - Masters see req_ready = 0.
- RSP:
  - owner_rsp_valid = mem_rd_rsp_valid; owner data/last = mem data/last, combinational pass-through.
  - mem_rd_rsp_ready = owner_rsp_ready.
  - Non-owner rsp_valid = 0; its data/last are driven to 0.
  - Each mem valid&ready increments beat_cnt, saturating at all-ones.
  - On valid&ready&last: last_owner <= owner, go to IDLE.
  - A new grant is possible in the cycle following return to IDLE, so minimum turnaround is 1 idle cycle.
- Latency: request accepted at cycle N; mem_rd_req_valid asserted at N+1. Zero added latency on response beats.
- Simultaneous requests in IDLE: exactly one is granted; the loser keeps valid high and is granted after the burst completes.
- Requests arriving during REQ/RSP: not acknowledged, held by the master.
- A last beat with backpressure (owner_rsp_ready = 0): stay in RSP until accepted.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when both masters request in IDLE, grant goes to the master != last_owner. A single requester is always granted.
- Undefined: fixed priority, D-cache over I-cache. last_owner is still maintained but unused for arbitration.

Decomposition:
- Package mem_arb_pkg holds the state encodings (IDLE/REQ/RSP one-hot), owner encodings (OWN_IC = 1'b0, OWN_DC = 1'b1), and the default widths.
- One natural sub-module, arb2_grant: 2-input combinational grant logic with last_owner input, priority or round-robin under the macro.
- Everything else stays in mem_rd_arbiter.

Test Plan:
- I-cache-only request, addr 0x0000_1A40; memory ready after 2 cycles returns 8 beats 0x11..0x88 -> mem_rd_req_addr = 0x0000_1A40; I-cache gets 8 beats in order with last on 0x88; dc_rd_rsp_valid stays 0; beat_cnt = 8.
- Both request in the same cycle (ic 0x100, dc 0x200) -> dc granted first; ic_rd_req_ready = 0 until dc's last beat, then ic accepted, giving mem addresses 0x200 then 0x100. With ARB_ROUND_ROBIN_EN and last_owner = DC, ic is granted first.
- Owner deasserts rsp_ready for 3 cycles mid-burst at beat 4 -> mem_rd_rsp_ready = 0 for those cycles; beat_cnt holds at 4; no beat lost or duplicated.
- Memory holds mem_rd_req_ready = 0 for 5 cycles -> mem_rd_req_valid stays 1 and addr stays stable; no master req_ready asserted meanwhile.
- rst pulsed during beat 3 of an I-cache burst -> next cycle: state IDLE, all valid/ready outputs 0, beat_cnt = 0; a fresh dc request after reset completes normally.
